// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared encodings for the count sequencer.
//   op_e    : command opcodes carried on cmd_op
//   state_e : controller states (IDLE accepts, RUN steps, DONE pulses)
package count_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_UP    = 2'b01,
        OP_DOWN  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/count_sequencer_if.sv
// count_sequencer_if: command handshake between a host and the count sequencer.
//   cmd_valid : command present (host)
//   cmd_ready : controller can accept (sequencer)
//   cmd_op    : opcode (host)
//   cmd_arg   : step count, or load value in the low bits (host)
interface count_sequencer_if #(
    parameter int unsigned LEN_W = 5
) ();
    import count_seq_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [LEN_W-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );

endinterface

// File: rtl/updown_counter.sv
// updown_counter: WIDTH-bit modulo up/down counter datapath.
//   clk, rst  : clock, synchronous active-high reset (q -> 0)
//   en, up    : step by one this edge, direction (1 = up)
//   load      : load load_val this edge (overrides en)
//   q         : registered count
//   wrap_next : the step taken at the coming edge rolls over
module updown_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap_next
);

    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
        end
    end

    // Roll-over: up from all-ones or down from zero; loads never count.
    assign wrap_next = en & ~load & (up ? (&q_q) : ~(|q_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: command-driven controller for an up/down counter.
//   clk, rst : clock, synchronous active-high reset
//   cmd      : slave side of the LOAD/UP/DOWN/CLEAR valid/ready handshake
//   pause    : freezes an in-progress run
//   count    : current counter value
//   busy     : high while stepping (RUN)
//   done     : one-cycle completion pulse
//   wrap     : one-cycle pulse after a roll-over step
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    count_sequencer_if.slave         cmd,
    input  logic                     pause,
    output logic [WIDTH-1:0]         count,
    output logic                     busy,
    output logic                     done,
    output logic                     wrap
);

    state_e           state_d, state_q;
    logic [LEN_W-1:0] remaining_d, remaining_q;
    logic             dir_up_d, dir_up_q;
    logic             done_d, done_q;
    logic             wrap_d, wrap_q;

    logic             ctr_en;
    logic             ctr_load;
    logic [WIDTH-1:0] ctr_load_val;
    logic             ctr_wrap_next;

    updown_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (ctr_en),
        .up        (dir_up_q),
        .load      (ctr_load),
        .load_val  (ctr_load_val),
        .q         (count),
        .wrap_next (ctr_wrap_next)
    );

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        dir_up_d     = dir_up_q;
        ctr_en       = 1'b0;
        ctr_load     = 1'b0;
        ctr_load_val = '0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    unique case (cmd.cmd_op)
                        OP_LOAD: begin
                            ctr_load     = 1'b1;
                            ctr_load_val = cmd.cmd_arg[WIDTH-1:0];
                            state_d      = S_DONE;
                        end
                        OP_CLEAR: begin
                            ctr_load = 1'b1;
                            state_d  = S_DONE;
                        end
                        OP_UP, OP_DOWN: begin
                            dir_up_d = (cmd.cmd_op == OP_UP);
                            if (cmd.cmd_arg == '0) begin
                                state_d = S_DONE;
                            end else begin
                                remaining_d = cmd.cmd_arg;
                                state_d     = S_RUN;
                            end
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (!pause) begin
                    ctr_en      = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Kept outside the FSM block: ctr_wrap_next depends on ctr_en.
    assign wrap_d = ctr_wrap_next;
    assign done_d = (state_d == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            dir_up_q    <= 1'b1;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dir_up_q    <= dir_up_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign busy          = (state_q == S_RUN);
    assign done          = done_q;
    assign wrap          = wrap_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed plan plus randomized traffic for count_sequencer,
// checked every cycle against a behavioural model of the command semantics.
module tb_count_sequencer;
    import count_seq_pkg::*;

    localparam int WIDTH = 4;
    localparam int LEN_W = 5;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             pause;
    logic [WIDTH-1:0] count;
    logic             busy, done, wrap;

    count_sequencer_if #(.LEN_W(LEN_W)) ifc ();

    count_sequencer #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (ifc.slave),
        .pause (pause),
        .count (count),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    function automatic void chk(string name, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    // Behavioural model: value, steps still owed, pending completion pulse.
    int m_count = 0;
    int m_left  = 0;
    bit m_up    = 1'b1;
    bit m_done  = 1'b0;
    bit m_wrap  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_count = 0; m_left = 0; m_done = 0; m_wrap = 0;
        end else if (m_done) begin
            m_done = 0; m_wrap = 0;
        end else if (m_left > 0) begin
            m_wrap = 0;
            if (!pause) begin
                m_wrap  = m_up ? (m_count == MOD - 1) : (m_count == 0);
                m_count = (m_count + (m_up ? 1 : MOD - 1)) % MOD;
                m_left--;
                if (m_left == 0) m_done = 1;
            end
        end else begin
            m_wrap = 0;
            if (ifc.cmd_valid) begin
                case (ifc.cmd_op)
                    OP_LOAD:  begin m_count = int'(ifc.cmd_arg) % MOD; m_done = 1; end
                    OP_CLEAR: begin m_count = 0; m_done = 1; end
                    default: begin
                        m_up = (ifc.cmd_op == OP_UP);
                        if (ifc.cmd_arg == 0) m_done = 1;
                        else m_left = int'(ifc.cmd_arg);
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", int'(count), m_count);
            chk("cmd_ready", int'(ifc.cmd_ready), int'(m_left == 0 && !m_done));
            chk("busy", int'(busy), int'(m_left > 0));
            chk("done", int'(done), int'(m_done));
            chk("wrap", int'(wrap), int'(m_wrap));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait (bounded) for ready, return 1 time unit after E0.
    task automatic send(input op_e op, input int arg);
        int k;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_arg   = LEN_W'(arg);
        k = 0;
        while (!ifc.cmd_ready && k < 64) begin
            tick();
            k++;
        end
        if (!ifc.cmd_ready) chk("send_ready_timeout", 0, 1);
        tick();
        ifc.cmd_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_c[5];
        int exp_w[5];
        int wraps;
        bit acc;

        rst = 1'b1; pause = 1'b0;
        ifc.cmd_valid = 1'b0; ifc.cmd_op = OP_LOAD; ifc.cmd_arg = '0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_count", int'(count), 0);
        chk("rst_ready", int'(ifc.cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wrap", int'(wrap), 0);
        rst = 1'b0;

        // LOAD 9
        send(OP_LOAD, 9);
        chk("load_count", int'(count), 9);
        chk("load_done", int'(done), 1);
        chk("load_ready_e0", int'(ifc.cmd_ready), 0);
        chk("load_wrap", int'(wrap), 0);
        tick();
        chk("load_done_off", int'(done), 0);
        chk("load_ready_e1", int'(ifc.cmd_ready), 1);

        // From 13, UP 5
        send(OP_LOAD, 13); tick();
        send(OP_UP, 5);
        chk("up5_busy_e0", int'(busy), 1);
        chk("up5_count_e0", int'(count), 13);
        exp_c = '{14, 15, 0, 1, 2};
        exp_w = '{0, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            chk("up5_done_early", int'(done), 0);
            tick();
            chk("up5_count", int'(count), exp_c[i]);
            chk("up5_wrap", int'(wrap), exp_w[i]);
        end
        chk("up5_done", int'(done), 1);
        chk("up5_busy_end", int'(busy), 0);
        tick();

        // From 1, DOWN 3 with a two-cycle pause after E1
        send(OP_LOAD, 1); tick();
        send(OP_DOWN, 3);
        tick();
        chk("dn3_e1_count", int'(count), 0);
        chk("dn3_e1_wrap", int'(wrap), 0);
        pause = 1'b1;
        tick();
        chk("dn3_p1_count", int'(count), 0);
        tick();
        chk("dn3_p2_count", int'(count), 0);
        chk("dn3_p2_busy", int'(busy), 1);
        pause = 1'b0;
        tick();
        chk("dn3_e2_count", int'(count), 15);
        chk("dn3_e2_wrap", int'(wrap), 1);
        tick();
        chk("dn3_e3_count", int'(count), 14);
        chk("dn3_e3_wrap", int'(wrap), 0);
        chk("dn3_done", int'(done), 1);
        tick();

        // From 4, UP 16: full circle with exactly one wrap
        send(OP_LOAD, 4); tick();
        send(OP_UP, 16);
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            wraps += int'(wrap);
        end
        chk("up16_count", int'(count), 4);
        chk("up16_done", int'(done), 1);
        chk("up16_wraps", wraps, 1);
        tick();

        // UP 0, then reset in the middle of DOWN 7
        send(OP_UP, 0);
        chk("up0_done", int'(done), 1);
        chk("up0_count", int'(count), 4);
        chk("up0_busy", int'(busy), 0);
        tick();
        send(OP_DOWN, 7);
        repeat (3) tick();
        chk("dn7_mid_count", int'(count), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_count", int'(count), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(ifc.cmd_ready), 1);
        tick();
        chk("abort_no_done", int'(done), 0);
        send(OP_LOAD, 5);
        chk("post_abort_count", int'(count), 5);
        chk("post_abort_done", int'(done), 1);
        tick();

        // Randomized traffic; the source holds a command until it is taken.
        for (int c = 0; c < 3000; c++) begin
            if (!ifc.cmd_valid && $urandom_range(0, 2) == 0) begin
                ifc.cmd_valid = 1'b1;
                ifc.cmd_op    = op_e'($urandom_range(0, 3));
                ifc.cmd_arg   = ($urandom_range(0, 7) == 0) ? LEN_W'(31)
                                                            : LEN_W'($urandom_range(0, 12));
            end
            pause = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            acc   = ifc.cmd_valid && ifc.cmd_ready && !rst;
            tick();
            if (acc) ifc.cmd_valid = 1'b0;
        end
        ifc.cmd_valid = 1'b0; pause = 1'b0; rst = 1'b0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
